fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, legal range 2..16, need not be a power of 2.
REQ-002 SHALL have parameter WIDTH, default 8: data width in bits.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum beats per grant, legal range 1..256.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port arst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid_i  in  N_REQ  per-requester data valid.
REQ-007 SHALL have port req_data_i  in  N_REQ x WIDTH  per-requester data, packed array indexed by requester.
REQ-008 SHALL have port req_ready_o  out  N_REQ  per-requester accept; at most one bit high.
REQ-009 SHALL have port fifo_full_i  in  1  full flag from the downstream FIFO.
REQ-010 SHALL have port fifo_write_o  out  1  write strobe to the FIFO.
REQ-011 SHALL have port fifo_data_o  out  WIDTH  write data to the FIFO.
REQ-012 SHALL have port grant_o  out  N_REQ  one-hot current owner; all zero when idle.
REQ-013 SHALL have port busy_o  out  1  high while in state GRANT.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and GRANT, with registers owner, rr_ptr ($clog2(N_REQ) bits) and beat_cnt ($clog2(MAX_BURST)+1 bits).
REQ-015 In IDLE with any req_valid_i set, the block SHALL select the first valid index at or after rr_ptr, searching upward with wrap N_REQ-1 -> 0, register it as owner, clear beat_cnt and enter GRANT on the next edge.
REQ-016 In IDLE with no valid request, the block SHALL stay in IDLE with req_ready_o, grant_o and fifo_write_o all zero.
REQ-017 Grant latency SHALL be exactly one cycle: req_ready_o cannot rise in the same cycle a request first appears in IDLE.
REQ-018 In GRANT: req_ready_o[owner] = ~fifo_full_i; all other ready bits SHALL be 0.
REQ-019 A beat is req_valid_i[owner] & req_ready_o[owner]; on a beat, fifo_write_o=1, fifo_data_o=req_data_i[owner] and beat_cnt increments.
REQ-020 When fifo_write_o=0, fifo_data_o SHALL be 0.
REQ-021 fifo_write_o SHALL never assert while fifo_full_i=1. A full cycle stalls the transfer without counting a beat or releasing the grant.
REQ-022 In GRANT, if req_valid_i[owner]=0, the block SHALL return to IDLE on the next edge.
REQ-023 In GRANT, if a beat occurs with beat_cnt = MAX_BURST-1, the block SHALL return to IDLE on the next edge.
REQ-024 On every GRANT -> IDLE transition, rr_ptr SHALL become owner+1, wrapping to 0 after N_REQ-1.
REQ-025 Requests from non-owners SHALL be ignored during GRANT and SHALL be re-evaluated in the next IDLE cycle; no requester waits more than N_REQ grants.
REQ-026 The IDLE cycle between grants SHALL be mandatory; back-to-back grants are separated by at least one idle cycle.
REQ-027 grant_o SHALL be the one-hot of owner in GRANT and 0 in IDLE; busy_o = (state==GRANT).

Reset
REQ-028 While arst=1, the block SHALL immediately force state=IDLE, owner=0, rr_ptr=0 and beat_cnt=0.
REQ-029 While arst=1, all outputs SHALL be 0 (req_ready_o, fifo_write_o, fifo_data_o, grant_o, busy_o).
REQ-030 Reset asserted mid-burst SHALL abort the burst without a partial write on that edge; the first grant after release SHALL go to requester 0 if it is valid.

Verification
REQ-031 Case N_REQ=4, MAX_BURST=4, full=0: req 1 valid alone with data 0x11..0x16 -> grant one cycle later; writes 0x11..0x14; IDLE; re-grant; writes 0x15, 0x16; rr_ptr=2.
REQ-032 Case: requesters 0..3 all continuously valid -> grant order 0,1,2,3,0, each 4 beats, with one idle cycle between grants.
REQ-033 Case: fifo_full_i=1 for 3 cycles during beat 2 -> fifo_write_o=0 and req_ready_o=0 for those cycles; beat count unchanged; burst resumes and totals 4 beats.
REQ-034 Case: owner 2 drops valid after 1 beat -> IDLE next cycle; rr_ptr=3; pending req 0 and req 3 -> req 3 granted.
REQ-035 Case: arst pulsed during beat 3 of owner 3 -> all outputs 0 within the reset cycle; after release, valid req 0 and req 3 -> req 0 granted.
REQ-036 Case: random traffic with a full model -> assert at most one ready bit, no write while full, and data order per requester preserved.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ requesters share one FIFO write port,
// each grant lasting up to MAX_BURST beats with a mandatory idle cycle between grants.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic                        fifo_full_i,
    output logic                        fifo_write_o,
    output logic [WIDTH-1:0]            fifo_data_o,
    output logic [N_REQ-1:0]            grant_o,
    output logic                        busy_o
);
    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [PW-1:0] owner, rr_ptr, pick, nxt_ptr;
    logic [BW-1:0] beat_cnt;
    logic          any_vld, beat;

    // Lowest valid index at/above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        logic [PW-1:0] hi, lo;
        logic          hi_vld;
        hi      = '0;
        lo      = '0;
        hi_vld  = 1'b0;
        any_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                lo      = PW'(i);
                any_vld = 1'b1;
                if (PW'(i) >= rr_ptr) begin
                    hi     = PW'(i);
                    hi_vld = 1'b1;
                end
            end
        end
        pick = hi_vld ? hi : lo;
    end

    assign nxt_ptr = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign beat    = (state == GRANT) && req_valid_i[owner] && !fifo_full_i;

    always_comb begin
        req_ready_o  = '0;
        grant_o      = '0;
        fifo_write_o = beat;
        fifo_data_o  = beat ? req_data_i[owner] : '0;
        busy_o       = (state == GRANT);
        if (state == GRANT) begin
            grant_o[owner]     = 1'b1;
            req_ready_o[owner] = !fifo_full_i;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        owner    <= pick;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req_valid_i[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= nxt_ptr;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BW'(MAX_BURST - 1)) begin
                            state  <= IDLE;
                            rr_ptr <= nxt_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks of fifo_wr_arbiter at N_REQ=4, WIDTH=8, MAX_BURST=4.
module tb_fifo_wr_arbiter;
    logic            clk = 1'b0;
    logic            arst;
    logic [3:0]      valid;
    logic [3:0][7:0] data;
    logic [3:0]      ready;
    logic            full;
    logic            fwr;
    logic [7:0]      fdata;
    logic [3:0]      grant;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;
    int ord[5] = '{0, 1, 2, 3, 0};
    int seq[4];

    fifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .arst(arst), .req_valid_i(valid), .req_data_i(data),
        .req_ready_o(ready), .fifo_full_i(full), .fifo_write_o(fwr),
        .fifo_data_o(fdata), .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [3:0] g, input logic [3:0] r,
                        input logic w, input logic [7:0] d);
        chk({tag, " grant"}, 32'(grant), 32'(g));
        chk({tag, " ready"}, 32'(ready), 32'(r));
        chk({tag, " write"}, 32'(fwr), 32'(w));
        chk({tag, " data"}, 32'(fdata), 32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick();
        arst = 1'b0;
    endtask

    initial begin
        arst  = 1'b1;
        valid = 4'b1111;
        full  = 1'b0;
        data  = '{8'h04, 8'h03, 8'h02, 8'h01};
        #2;
        outs("reset", 4'b0000, 4'b0000, 1'b0, 8'h00);
        chk("reset busy", 32'(busy), 32'd0);
        tick();
        tick();
        arst = 1'b0;

        // Lone requester 1: 4-beat burst, idle, 2 more beats, then rr_ptr lands on 2
        valid   = 4'b0010;
        data[1] = 8'h11;
        @(negedge clk); outs("t1 latency", 4'b0000, 4'b0000, 1'b0, 8'h00); tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); outs("t1 beat", 4'b0010, 4'b0010, 1'b1, 8'(8'h11 + k)); tick();
            data[1] = data[1] + 8'h1;
        end
        @(negedge clk); outs("t1 gap", 4'b0000, 4'b0000, 1'b0, 8'h00); tick();
        for (int k = 4; k < 6; k++) begin
            @(negedge clk); outs("t1 regrant", 4'b0010, 4'b0010, 1'b1, 8'(8'h11 + k)); tick();
            data[1] = data[1] + 8'h1;
        end
        valid = 4'b0000;
        @(negedge clk); outs("t1 drop", 4'b0010, 4'b0010, 1'b0, 8'h00); tick();
        valid   = 4'b0110;
        data[2] = 8'h22;
        @(negedge clk); outs("t1 idle", 4'b0000, 4'b0000, 1'b0, 8'h00); tick();
        @(negedge clk); chk("t1 rr_ptr=2 grant", 32'(grant), 32'(4'b0100)); tick();
        valid = 4'b0000;
        tick();

        // All requesters valid: order 0,1,2,3,0 with an idle cycle before each grant
        do_reset();
        valid = 4'b1111;
        data  = '{8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk("t2 idle grant", 32'(grant), 32'd0);
            chk("t2 idle busy", 32'(busy), 32'd0);
            tick();
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                outs("t2 beat", 4'(1 << ord[g]), 4'(1 << ord[g]), 1'b1, 8'(8'hA0 + ord[g]));
                tick();
            end
        end
        valid = 4'b0000;
        tick();

        // Full stall of 3 cycles on beat 2
        do_reset();
        valid   = 4'b0001;
        data[0] = 8'h20;
        @(negedge clk); outs("t3 idle", 4'b0000, 4'b0000, 1'b0, 8'h00); tick();
        @(negedge clk); outs("t3 beat1", 4'b0001, 4'b0001, 1'b1, 8'h20); tick();
        data[0] = 8'h21;
        full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            outs("t3 stall", 4'b0001, 4'b0000, 1'b0, 8'h00);
            chk("t3 stall busy", 32'(busy), 32'd1);
            tick();
        end
        full = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); outs("t3 resume", 4'b0001, 4'b0001, 1'b1, 8'(8'h20 + k)); tick();
            data[0] = data[0] + 8'h1;
        end
        @(negedge clk); outs("t3 total4", 4'b0000, 4'b0000, 1'b0, 8'h00); tick();
        valid = 4'b0000;
        tick();

        // Owner 2 drops after one beat; rr_ptr=3 so req 3 beats req 0
        do_reset();
        valid   = 4'b0100;
        data[2] = 8'h40;
        @(negedge clk); outs("t4 idle", 4'b0000, 4'b0000, 1'b0, 8'h00); tick();
        @(negedge clk); outs("t4 beat1", 4'b0100, 4'b0100, 1'b1, 8'h40); tick();
        valid   = 4'b1001;
        data[0] = 8'h50;
        data[3] = 8'h30;
        @(negedge clk); outs("t4 drop", 4'b0100, 4'b0100, 1'b0, 8'h00); tick();
        @(negedge clk); outs("t4 idle2", 4'b0000, 4'b0000, 1'b0, 8'h00); tick();
        @(negedge clk); outs("t4 req3", 4'b1000, 4'b1000, 1'b1, 8'h30); tick();
        data[3] = 8'h31;

        // Reset during owner 3 beat 3, then req 0 wins
        @(negedge clk); outs("t5 beat2", 4'b1000, 4'b1000, 1'b1, 8'h31); tick();
        data[3] = 8'h32;
        arst = 1'b1;
        #1;
        outs("t5 in reset", 4'b0000, 4'b0000, 1'b0, 8'h00);
        chk("t5 in reset busy", 32'(busy), 32'd0);
        tick();
        outs("t5 reset edge", 4'b0000, 4'b0000, 1'b0, 8'h00);
        arst = 1'b0;
        @(negedge clk); outs("t5 idle", 4'b0000, 4'b0000, 1'b0, 8'h00); tick();
        @(negedge clk); outs("t5 req0", 4'b0001, 4'b0001, 1'b1, 8'h50); tick();
        valid = 4'b0000;
        tick();

        // Random traffic: one-hot ready, no write while full, per-requester order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i]  = 0;
            data[i] = {2'(i), 6'd0};
        end
        for (int c = 0; c < 300; c++) begin
            int  idx;
            logic wrote;
            valid = 4'($urandom);
            full  = ($urandom_range(0, 3) == 0);
            idx   = 0;
            @(negedge clk);
            chk("rnd onehot ready", 32'($countones(ready) <= 1), 32'd1);
            chk("rnd write while full", 32'(fwr && full), 32'd0);
            wrote = fwr;
            if (wrote) begin
                for (int i = 0; i < 4; i++) if (ready[i]) idx = i;
                chk("rnd write valid", 32'(valid[idx]), 32'd1);
                chk("rnd order", 32'(fdata), 32'({2'(idx), 6'(seq[idx])}));
            end
            tick();
            if (wrote) begin
                seq[idx]++;
                data[idx] = {2'(idx), 6'(seq[idx])};
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
